// File: rtl/key_debounce.sv
// Multi-channel push-button conditioner: 2-flop synchroniser, debounce FSM and
// hold counter per key, producing a stable level plus press/release/long pulses.
module key_debounce #(
  parameter int KEY_W    = 3,
  parameter int DEB_CNT  = 1_000_000,
  parameter int LONG_CNT = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_level,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long
);

  localparam int CNT_W  = $clog2(DEB_CNT);
  localparam int HOLD_W = $clog2(LONG_CNT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEB_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CNT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_WT = 2'd1,
    HELD     = 2'd2,
    REL_WT   = 2'd3
  } state_t;

  logic [KEY_W-1:0] sync1_r;
  logic [KEY_W-1:0] sync2_r;

  // Synchroniser: idles at 1 (released) so reset never looks like a press
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= {KEY_W{1'b1}};
      sync2_r <= {KEY_W{1'b1}};
    end else begin
      sync1_r <= key_in;
      sync2_r <= sync1_r;
    end
  end

  for (genvar i = 0; i < KEY_W; i++) begin : g_ch
    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [HOLD_W-1:0]   hold_r, hold_s;
    logic                level_r, level_s;
    logic                press_r, press_s;
    logic                release_r, release_s;
    logic                long_r, long_s;
    logic                s_key_s;

    assign s_key_s = sync2_r[i];

    // Next-state and pulse decode; hold is frozen (not cleared) across release bounce
    always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      hold_s    = hold_r;
      level_s   = level_r;
      press_s   = 1'b0;
      release_s = 1'b0;
      long_s    = 1'b0;
      case (state_r)
        IDLE: begin
          if (!s_key_s) begin
            state_s = PRESS_WT;
            cnt_s   = {CNT_W{1'b0}};
          end else begin
            state_s = IDLE;
          end
        end
        PRESS_WT: begin
          if (s_key_s) begin
            state_s = IDLE;
          end else if (cnt_r == CNT_LAST) begin
            state_s = HELD;
            press_s = 1'b1;
            level_s = 1'b1;
            hold_s  = {HOLD_W{1'b0}};
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        HELD: begin
          if (s_key_s) begin
            state_s = REL_WT;
            cnt_s   = {CNT_W{1'b0}};
          end else begin
            if (hold_r != HOLD_MAX) begin
              hold_s = hold_r + HOLD_W'(1);
            end else begin
              hold_s = hold_r;
            end
            if (hold_r == HOLD_LAST) begin
              long_s = 1'b1;
            end else begin
              long_s = 1'b0;
            end
          end
        end
        REL_WT: begin
          if (!s_key_s) begin
            state_s = HELD;
          end else if (cnt_r == CNT_LAST) begin
            state_s   = IDLE;
            release_s = 1'b1;
            level_s   = 1'b0;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
          hold_s  = {HOLD_W{1'b0}};
          level_s = 1'b0;
        end
      endcase
    end

    // Channel state and registered outputs
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r   <= IDLE;
        cnt_r     <= {CNT_W{1'b0}};
        hold_r    <= {HOLD_W{1'b0}};
        level_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
      end else begin
        state_r   <= state_s;
        cnt_r     <= cnt_s;
        hold_r    <= hold_s;
        level_r   <= level_s;
        press_r   <= press_s;
        release_r <= release_s;
        long_r    <= long_s;
      end
    end

    assign key_level[i]   = level_r;
    assign key_press[i]   = press_r;
    assign key_release[i] = release_r;
    assign key_long[i]    = long_r;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with DEB_CNT=10, LONG_CNT=50, KEY_W=3.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] key_in;
  logic [2:0] key_level;
  logic [2:0] key_press;
  logic [2:0] key_release;
  logic [2:0] key_long;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         cyc;
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] lng;
  } ev_t;

  ev_t exp_q[$];

  key_debounce #(
    .KEY_W   (3),
    .DEB_CNT (10),
    .LONG_CNT(50)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse the DUT presents must match the next expected event
  always @(negedge clk) begin
    if ((key_press | key_release | key_long) != 3'b000) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_pulse cyc=%0d press=%b rel=%b long=%b", cyc, key_press, key_release, key_long);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.press != key_press || e.rel != key_release || e.lng != key_long) begin
          n_errors++;
          $display("FAIL event got cyc=%0d p=%b r=%b l=%b expected cyc=%0d p=%b r=%b l=%b",
                   cyc, key_press, key_release, key_long, e.cyc, e.press, e.rel, e.lng);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [2:0] p, input logic [2:0] r, input logic [2:0] l);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.lng = l;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s got=%b expected=%b cyc=%0d", name, act, req, cyc);
    end
  endtask

  initial begin
    rst    = 1'b1;
    key_in = 3'b111;
    tick(3);
    chk("reset_level", key_level, 3'b000);
    chk("reset_press", key_press, 3'b000);
    chk("reset_release", key_release, 3'b000);
    chk("reset_long", key_long, 3'b000);
    rst = 1'b0;
    tick(2);

    // Clean press on key 0, then release bounce, then real release
    key_in = 3'b110;
    push(cyc + 13, 3'b001, 3'b000, 3'b000);
    tick(14);
    chk("press_level", key_level, 3'b001);
    key_in = 3'b111;
    tick(5);
    key_in = 3'b110;
    tick(10);
    chk("rel_bounce_level", key_level, 3'b001);
    key_in = 3'b111;
    push(cyc + 13, 3'b000, 3'b001, 3'b000);
    tick(16);
    chk("release_level", key_level, 3'b000);

    // Press bounce on key 1
    key_in = 3'b101; tick(6);
    key_in = 3'b111; tick(2);
    key_in = 3'b101; tick(6);
    key_in = 3'b111; tick(20);
    chk("bounce_level", key_level, 3'b000);

    // Long hold on key 2
    key_in = 3'b011;
    push(cyc + 13, 3'b100, 3'b000, 3'b000);
    push(cyc + 63, 3'b000, 3'b000, 3'b100);
    tick(80);
    chk("long_level", key_level, 3'b100);
    key_in = 3'b111;
    push(cyc + 13, 3'b000, 3'b100, 3'b000);
    tick(16);
    chk("long_rel_level", key_level, 3'b000);

    // All keys together
    key_in = 3'b000;
    push(cyc + 13, 3'b111, 3'b000, 3'b000);
    tick(20);
    chk("simul_level", key_level, 3'b111);
    key_in = 3'b111;
    push(cyc + 13, 3'b000, 3'b111, 3'b000);
    tick(16);
    chk("simul_rel_level", key_level, 3'b000);

    // Reset while key 0 is in PRESS_WT
    key_in = 3'b110;
    tick(5);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_level", key_level, 3'b000);
    chk("rst_mid_press", key_press, 3'b000);
    rst = 1'b0;
    push(cyc + 13, 3'b001, 3'b000, 3'b000);
    tick(1);
    chk("post_rst_level", key_level, 3'b000);
    tick(13);
    chk("requal_level", key_level, 3'b001);
    key_in = 3'b111;
    push(cyc + 13, 3'b000, 3'b001, 3'b000);

    for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick(1);
    tick(5);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL missing_events got=%0d pending expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
